// File: rtl/sprite_pixel_pipe.sv
// rtl/sprite_pixel_pipe.sv - three-stage sprite hit/ROM/palette pixel pipeline with aligned sync delay
// Colour and hs/vs/blank advance together on pix_en so they stay aligned at the VGA pins.
`timescale 1ns/1ps
module sprite_pixel_pipe #(
  parameter int SPR_W  = 32,
  parameter int SPR_H  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pix_en,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              hs_in,
  input  logic              vs_in,
  input  logic              blank_in,
  input  logic [9:0]        SprX,
  input  logic [9:0]        SprY,
  input  logic [11:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        Red,
  output logic [3:0]        Green,
  output logic [3:0]        Blue,
  output logic              hs_out,
  output logic              vs_out,
  output logic              blank_out
);

  localparam int          XW      = $clog2(SPR_W);
  localparam int          YW      = $clog2(SPR_H);
  localparam logic [10:0] SPR_W_L = 11'(SPR_W);
  localparam logic [10:0] SPR_H_L = 11'(SPR_H);

  logic        vs_q;
  logic [9:0]  spr_x_l;
  logic [9:0]  spr_y_l;

  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              hit_next;
  logic [ADDR_W-1:0] addr_next;

  logic        hit1, hs1, vs1, blank1;
  logic [3:0]  idx2;
  logic        hit2, hs2, vs2, blank2;
  logic [11:0] rgb3;
  logic [11:0] pix_rgb;
  logic [11:0] pal [16];

  // Sprite position only moves on the vs falling edge, so a frame never tears.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_q    <= 1'b1;
      spr_x_l <= '0;
      spr_y_l <= '0;
    end else begin
      vs_q <= vs_in;
      if (vs_q && !vs_in) begin
        spr_x_l <= SprX;
        spr_y_l <= SprY;
      end
    end
  end

  assign dx        = {1'b0, DrawX} - {1'b0, spr_x_l};
  assign dy        = {1'b0, DrawY} - {1'b0, spr_y_l};
  assign hit_next  = !dx[10] && (dx < SPR_W_L) && !dy[10] && (dy < SPR_H_L);
  assign addr_next = ADDR_W'({dy[YW-1:0], dx[XW-1:0]});

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr  <= '0;
      hit1      <= 1'b0;
      hs1       <= 1'b1;
      vs1       <= 1'b1;
      blank1    <= 1'b0;
      idx2      <= '0;
      hit2      <= 1'b0;
      hs2       <= 1'b1;
      vs2       <= 1'b1;
      blank2    <= 1'b0;
      rgb3      <= '0;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      blank_out <= 1'b0;
    end else if (pix_en) begin
      rom_addr  <= addr_next;
      hit1      <= hit_next;
      hs1       <= hs_in;
      vs1       <= vs_in;
      blank1    <= blank_in;
      idx2      <= rom_data;
      hit2      <= hit1;
      hs2       <= hs1;
      vs2       <= vs1;
      blank2    <= blank1;
      rgb3      <= pix_rgb;
      hs_out    <= hs2;
      vs_out    <= vs2;
      blank_out <= blank2;
    end
  end

  // Index 0 is transparent; blanking forces black regardless of the sprite.
  always_comb begin
    pix_rgb = bg_rgb;
    if (!blank2) begin
      pix_rgb = '0;
    end else if (hit2 && (idx2 != 4'd0)) begin
      pix_rgb = pal[idx2];
    end
  end

  // A write landing on the same edge as an S3 read is seen from the next pixel on.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) begin
        pal[i] <= '0;
      end
    end else if (pal_we) begin
      pal[pal_idx] <= pal_rgb;
    end
  end

  assign Red   = rgb3[11:8];
  assign Green = rgb3[7:4];
  assign Blue  = rgb3[3:0];

endmodule

// File: tb/tb_sprite_pixel_pipe.sv
// tb/tb_sprite_pixel_pipe.sv - directed and random checks of sprite_pixel_pipe against a pixel-level model
`timescale 1ns/1ps
module tb_sprite_pixel_pipe;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        pix_en = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        hs_in = 1'b1;
  logic        vs_in = 1'b1;
  logic        blank_in = 1'b1;
  logic [9:0]  SprX = '0;
  logic [9:0]  SprY = '0;
  logic [11:0] bg_rgb = '0;
  logic [9:0]  rom_addr;
  logic [3:0]  rom_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [11:0] pal_rgb = '0;
  logic [3:0]  Red, Green, Blue;
  logic        hs_out, vs_out, blank_out;

  sprite_pixel_pipe #(.SPR_W(32), .SPR_H(32), .ADDR_W(10)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pix_en(pix_en),
    .DrawX(DrawX), .DrawY(DrawY),
    .hs_in(hs_in), .vs_in(vs_in), .blank_in(blank_in),
    .SprX(SprX), .SprY(SprY), .bg_rgb(bg_rgb),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .Red(Red), .Green(Green), .Blue(Blue),
    .hs_out(hs_out), .vs_out(vs_out), .blank_out(blank_out)
  );

  always #10 Clk = ~Clk;

  logic [3:0] rom_mem [1024];
  always @(posedge Clk) rom_data <= rom_mem[rom_addr];

  typedef struct {
    logic       bl;
    logic       hs;
    logic       vs;
    logic       hit;
    logic [3:0] idx;
  } ent_t;

  int          checks = 0;
  int          errors = 0;
  ent_t        q[$];
  int          mx, my;
  logic        m_vs_prev;
  logic [11:0] pal_m [16];
  logic        wr_en = 1'b0;
  logic        wr_strobe = 1'b0;
  logic [3:0]  wr_idx = '0;
  logic [11:0] wr_rgb = '0;

  localparam int IX = 600;
  localparam int IY = 400;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rgb_now();
    return {4'h0, Red, Green, Blue};
  endfunction

  function automatic logic [15:0] sync_now();
    return {13'h0, hs_out, vs_out, blank_out};
  endfunction

  function automatic logic [11:0] colour(input ent_t f);
    if (!f.bl) return 12'h000;
    if (f.hit && f.idx != 4'd0) return pal_m[f.idx];
    return bg_rgb;
  endfunction

  task automatic model_reset();
    ent_t r;
    r = '{bl: 1'b0, hs: 1'b1, vs: 1'b1, hit: 1'b0, idx: 4'd0};
    q.delete();
    q.push_back(r);
    q.push_back(r);
    mx = 0;
    my = 0;
    m_vs_prev = 1'b1;
    for (int i = 0; i < 16; i++) pal_m[i] = 12'h000;
  endtask

  task automatic do_reset();
    pix_en  = 1'b0;
    vs_in   = 1'b1;
    Reset_n = 1'b0;
    #1;
    check("reset_rgb", rgb_now(), 16'h0000);
    check("reset_sync", sync_now(), 16'h0006);
    check("reset_rom_addr", 16'(rom_addr), 16'h0000);
    @(posedge Clk);
    @(posedge Clk);
    #1 Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic pal_write(input logic [3:0] idx, input logic [11:0] rgb);
    pal_we  = 1'b1;
    pal_idx = idx;
    pal_rgb = rgb;
    pal_m[idx] = rgb;
    @(posedge Clk);
    #1 pal_we = 1'b0;
  endtask

  task automatic step(input int x, input int y, input logic hs, input logic vs, input logic bl);
    ent_t        e, f;
    int          dx, dy;
    logic [11:0] exp_rgb;
    logic [15:0] exp_sync;
    logic [15:0] exp_addr;
    DrawX    = 10'(x);
    DrawY    = 10'(y);
    hs_in    = hs;
    vs_in    = vs;
    blank_in = bl;
    pix_en   = 1'b1;
    pal_we   = wr_en && wr_strobe;
    pal_idx  = wr_idx;
    pal_rgb  = wr_rgb;
    dx = x - mx;
    dy = y - my;
    e.bl  = bl;
    e.hs  = hs;
    e.vs  = vs;
    e.hit = (dx >= 0) && (dx < 32) && (dy >= 0) && (dy < 32);
    exp_addr = 16'(((dy & 31) * 32) + (dx & 31));
    e.idx = rom_mem[exp_addr[9:0]];
    if (m_vs_prev && !vs) begin
      mx = int'(SprX);
      my = int'(SprY);
    end
    m_vs_prev = vs;
    q.push_back(e);
    f = q.pop_front();
    exp_rgb  = colour(f);
    exp_sync = {13'h0, f.hs, f.vs, f.bl};
    if (pal_we) pal_m[wr_idx] = wr_rgb;
    @(posedge Clk);
    #1;
    check("rom_addr", 16'(rom_addr), exp_addr);
    check("pixel_rgb", rgb_now(), {4'h0, exp_rgb});
    check("pixel_sync", sync_now(), exp_sync);
    pix_en = 1'b0;
    pal_we = wr_en && !wr_strobe;
    if (pal_we) pal_m[wr_idx] = wr_rgb;
    wr_en = 1'b0;
    @(posedge Clk);
    #1;
    pal_we = 1'b0;
    check("hold_rgb", rgb_now(), {4'h0, exp_rgb});
    check("hold_sync", sync_now(), exp_sync);
  endtask

  task automatic idle();
    step(IX, IY, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y;
    logic hsv, vsv, blv;
    for (int a = 0; a < 1024; a++) rom_mem[a] = 4'(a);
    SprX   = 10'd100;
    SprY   = 10'd50;
    bg_rgb = 12'h135;
    #3;
    do_reset();

    // sprite sits at (0,0) until the first vs falling edge
    pal_write(4'd5, 12'hF00);
    step(5, 0, 1'b1, 1'b1, 1'b1);
    idle();
    idle();
    check("origin_before_latch", rgb_now(), 16'h0F00);

    step(IX, IY, 1'b1, 1'b0, 1'b0);
    step(IX, IY, 1'b1, 1'b1, 1'b0);

    step(105, 50, 1'b1, 1'b1, 1'b1);
    check("hit_addr", 16'(rom_addr), 16'd5);
    step(99, 50, 1'b1, 1'b1, 1'b1);
    step(132, 50, 1'b1, 1'b1, 1'b1);
    check("hit_rgb", rgb_now(), 16'h0F00);
    step(105, 82, 1'b1, 1'b1, 1'b1);
    check("left_miss", rgb_now(), 16'h0135);
    step(100, 50, 1'b1, 1'b1, 1'b1);
    check("right_miss", rgb_now(), 16'h0135);
    step(105, 50, 1'b1, 1'b1, 1'b0);
    check("below_miss", rgb_now(), 16'h0135);
    idle();
    check("transparent", rgb_now(), 16'h0135);
    idle();
    check("blank_black", rgb_now(), 16'h0000);

    step(105, 50, 1'b0, 1'b1, 1'b1);
    check("lat_n0_hs", 16'(hs_out), 16'd1);
    idle();
    check("lat_n1_hs", 16'(hs_out), 16'd1);
    check("lat_n1_rgb", rgb_now(), 16'h0135);
    idle();
    check("lat_n2_hs", 16'(hs_out), 16'd0);
    check("lat_n2_rgb", rgb_now(), 16'h0F00);

    SprX = 10'd200;
    step(105, 50, 1'b1, 1'b1, 1'b1);
    step(205, 50, 1'b1, 1'b1, 1'b1);
    idle();
    check("midframe_old_pos", rgb_now(), 16'h0F00);
    idle();
    check("midframe_new_pos_miss", rgb_now(), 16'h0135);
    step(IX, IY, 1'b1, 1'b0, 1'b1);
    idle();
    step(205, 50, 1'b1, 1'b1, 1'b1);
    idle();
    idle();
    check("next_frame_new_pos", rgb_now(), 16'h0F00);

    step(205, 50, 1'b1, 1'b1, 1'b1);
    idle();
    wr_en = 1'b1; wr_strobe = 1'b1; wr_idx = 4'd5; wr_rgb = 12'h0F0;
    idle();
    check("collision_old", rgb_now(), 16'h0F00);
    step(205, 50, 1'b1, 1'b1, 1'b1);
    idle();
    idle();
    check("collision_new", rgb_now(), 16'h00F0);

    step(205, 50, 1'b1, 1'b1, 1'b1);
    step(205, 50, 1'b1, 1'b1, 1'b1);
    #5;
    do_reset();
    pal_write(4'd5, 12'h0F0);
    step(5, 0, 1'b1, 1'b1, 1'b1);
    idle();
    idle();
    check("post_reset_origin", rgb_now(), 16'h00F0);

    for (int a = 0; a < 1024; a++) rom_mem[a] = 4'($urandom);
    do_reset();
    for (int i = 0; i < 16; i++) pal_write(4'(i), 12'($urandom));
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 10) begin
        SprX = 10'($urandom_range(0, 639));
        SprY = 10'($urandom_range(0, 479));
      end
      vsv = (i % 50 == 49) ? 1'b0 : 1'b1;
      x = mx + int'($urandom_range(0, 40)) - 4;
      y = my + int'($urandom_range(0, 40)) - 4;
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      hsv = ($urandom_range(0, 7) != 0);
      blv = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 3) == 0) bg_rgb = 12'($urandom);
      if ($urandom_range(0, 4) == 0) begin
        wr_en     = 1'b1;
        wr_strobe = 1'($urandom_range(0, 1));
        wr_idx    = 4'($urandom);
        wr_rgb    = 12'($urandom);
      end
      step(x, y, hsv, vsv, blv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_pipe.md
# sprite_pixel_pipe

Pixel-generation stage between the VGA timing generator and the VGA output pins. Each pixel it checks whether the raster position (DrawX/DrawY) falls inside a 32x32 sprite. Inside the sprite it fetches a 4-bit palette index from an external synchronous sprite ROM and maps it to 12-bit RGB through a writable 16-entry palette; outside, it outputs a background colour. It delays hs/vs/blank by the same pipeline depth, so colour and sync stay aligned at the connector.

## Interface
- SPR_W, 32, sprite width in pixels (power of two)
- SPR_H, 32, sprite height in pixels
- ADDR_W, 10, ROM address width; equals log2(SPR_W*SPR_H)
- Clk  in  1  system clock, 50 MHz; sole clock
- Reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  one-Clk strobe per pixel (every 2nd Clk); the pipeline advances only when high
- DrawX, DrawY  in  10  current raster position from vga_controller
- hs_in, vs_in  in  1  active-low syncs from vga_controller
- blank_in  in  1  1 = visible area, 0 = blanking
- SprX, SprY  in  10  sprite top-left position, driven by the motion logic
- bg_rgb  in  12  background colour {R,G,B}
- rom_addr  out  ADDR_W  sprite ROM address
- rom_data  in  4  palette index; valid one Clk after rom_addr
- pal_we  in  1  palette write strobe
- pal_idx  in  4  palette write index
- pal_rgb  in  12  palette write data
- Red, Green, Blue  out  4 each  pixel colour to VGA pins
- hs_out, vs_out, blank_out  out  1  delayed syncs/blank

## Operation
- **Position latch.** SprX_l/SprY_l load SprX/SprY on the Clk where the registered vs_in was 1 and the current vs_in is 0 (vs falling edge). This happens regardless of pix_en. Position therefore changes only between frames, which prevents tearing.
- **Stage S1** (on pix_en):
  - dx = {1'b0,DrawX} - {1'b0,SprX_l} and dy = {1'b0,DrawY} - {1'b0,SprY_l}, both 11-bit.
  - hit1 = (dx[10]==0 && dx < SPR_W && dy[10]==0 && dy < SPR_H).
  - addr1 = dy[log2 SPR_H-1:0]*SPR_W + dx[log2 SPR_W-1:0].
  - hs1, vs1 and blank1 register the matching inputs.
  - rom_addr = addr1 (registered output).
  - Sprites extending past 639/479 are clipped by the raster itself; no wrap.
- **Stage S2** (on pix_en): idx2 = rom_data; hit2 = hit1; sync/blank shift.
- **Stage S3** (on pix_en):
  - {Red,Green,Blue} = 0 if blank2 == 0.
  - Otherwise, pal[idx2] if hit2 and idx2 != 0.
  - Otherwise, bg_rgb. Index 0 is transparent.
  - hs_out/vs_out/blank_out = hs2/vs2/blank2.
- **Palette.** 16x12 register array.
  - Written on any Clk with pal_we = 1, independent of pix_en.
  - A write and an S3 read of the same index on the same Clk: the read returns the old value; the new value is used from the next pix_en.
  - Writes to index 0 are stored but never displayed.
- When pix_en = 0, all pipeline registers and outputs hold.

## Timing
- Latency: DrawX/hs_in/vs_in/blank_in sampled at pix_en strobe N appear at the outputs after strobe N+2 (3 register stages, 6 Clk at 50 MHz).
- ROM contract: rom_data is valid 1 Clk after rom_addr changes. Since pix_en occurs every 2nd Clk, S2 always captures settled data.
- Reset (asynchronous, Reset_n = 0) values:
  - Red/Green/Blue = 0; blank_out = 0; hs_out = 1; vs_out = 1.
  - rom_addr = 0; all pipeline registers 0 except syncs = 1.
  - SprX_l = SprY_l = 0; all palette entries = 0.
- Reset mid-frame: outputs go to their reset values immediately. Valid colour resumes 3 pix_en strobes after release. Position latches at the next vs falling edge; until then the sprite is drawn at (0,0).

## Test plan
- **Reset.** Assert Reset_n = 0 mid-line -> outputs 0/0/0, hs_out = vs_out = 1, blank_out = 0 within the same Clk (asynchronous), no pix_en required.
- **Latency/alignment.** Toggle hs_in low at strobe N -> hs_out low exactly after strobe N+2. Red/Green/Blue for that pixel change on the same Clk.
- **Hit/address.** SprX = 100, SprY = 50, ROM returns addr[3:0], pal[5] = 12'hF00.
  - DrawX = 105, DrawY = 50 -> rom_addr = 5; output F/0/0.
  - DrawX = 99 or 132 -> bg_rgb.
  - DrawY = 82 -> bg_rgb.
- **Transparency/blank.**
  - rom_data = 0 inside the sprite -> bg_rgb.
  - blank_in = 0 inside the sprite -> 0/0/0.
- **Position latch.** Change SprX from 100 to 200 mid-frame -> the remainder of the frame still draws at 100. The frame after the vs falling edge draws at 200.
- **Palette collision.** Write pal[5] = 12'h0F0 on the same Clk that S3 reads index 5 -> that pixel shows F/0/0; the next pixel with index 5 shows 0/F/0.
